// File: rtl/qspi_pkg.sv
// Shared QSPI definitions: lane-mode encodings, packer states
// and the per-sample bit count helper.
package qspi_pkg;

  typedef enum logic [1:0] {
    LANE_SINGLE = 2'b00,
    LANE_DUAL   = 2'b01,
    LANE_QUAD   = 2'b10
  } lane_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    FINISH = 2'b10
  } pk_state_e;

  // Mode 2'b11 falls back to single-lane.
  function automatic logic [3:0] bits_per_sample(
    input logic [1:0] lanes
  );
    logic [3:0] n;
    n = 4'd1;
    unique case (1'b1)
      (lanes == LANE_DUAL): n = 4'd2;
      (lanes == LANE_QUAD): n = 4'd4;
      default:              n = 4'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/qspi_rx_packer.sv
// Assembles sampled QSPI lanes MSB-first into bytes and packs
// them little-endian into FIFO words for the RX FIFO.
module qspi_rx_packer
  import qspi_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_bytes_i,
  input  logic [1:0]       lanes_i,
  input  logic             abort_i,
  input  logic             sample_i,
  input  logic [3:0]       io_i,
  input  logic             fifo_full_i,
  output logic             fifo_wr_en_o,
  output logic [WIDTH-1:0] fifo_wr_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o
);

  localparam int NB    = WIDTH / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  pk_state_e        r_state;
  logic [1:0]       r_lanes;
  logic [LEN_W-1:0] r_bytes_left;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_byte;
  logic [IDX_W-1:0] r_byte_idx;
  logic [WIDTH-1:0] r_word;
  logic             r_push_pend;
  logic [WIDTH-1:0] r_push_data;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;

  logic [3:0]       w_sum;
  logic             w_byte_done;
  logic [7:0]       w_next_byte;
  logic [WIDTH-1:0] w_word_ins;
  logic             w_last;
  logic             w_word_full;

  assign w_sum       = {1'b0, r_bit_cnt}
                     + bits_per_sample(r_lanes);
  assign w_byte_done = w_sum[3];
  assign w_last      = (r_bytes_left == LEN_W'(1));
  assign w_word_full = (r_byte_idx == IDX_W'(NB - 1));

  always_comb begin
    w_next_byte = {r_byte[6:0], io_i[1]};
    unique case (1'b1)
      (r_lanes == LANE_DUAL):
        w_next_byte = {r_byte[5:0], io_i[1:0]};
      (r_lanes == LANE_QUAD):
        w_next_byte = {r_byte[3:0], io_i[3:0]};
      default:
        w_next_byte = {r_byte[6:0], io_i[1]};
    endcase
  end

  always_comb begin
    w_word_ins = r_word;
    for (int k = 0; k < NB; k++) begin
      if (r_byte_idx == IDX_W'(k))
        w_word_ins[8*k +: 8] = w_next_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_lanes      <= '0;
      r_bytes_left <= '0;
      r_bit_cnt    <= '0;
      r_byte       <= '0;
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_push_pend  <= 1'b0;
      r_push_data  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_push_pend <= 1'b0;
      unique case (r_state)
        IDLE, FINISH: begin
          r_state <= IDLE;
          if (start_i) begin
            r_ovf      <= 1'b0;
            r_lanes    <= lanes_i;
            r_bit_cnt  <= '0;
            r_byte     <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            if (len_bytes_i == '0) begin
              r_done <= 1'b1;
            end else begin
              r_bytes_left <= len_bytes_i;
              r_busy       <= 1'b1;
              r_state      <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (abort_i) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_bit_cnt  <= '0;
            r_byte     <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
          end else if (sample_i) begin
            r_bit_cnt <= w_sum[2:0];
            r_byte    <= w_byte_done ? 8'h00 : w_next_byte;
            if (w_byte_done) begin
              r_bytes_left <= r_bytes_left - 1'b1;
              if (w_last || w_word_full) begin
                r_push_pend <= 1'b1;
                r_push_data <= w_word_ins;
                r_word      <= '0;
                r_byte_idx  <= '0;
              end else begin
                r_word     <= w_word_ins;
                r_byte_idx <= r_byte_idx + 1'b1;
              end
              if (w_last) begin
                r_state <= FINISH;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      // A drop in this cycle outranks a start clearing the flag.
      if (r_push_pend && fifo_full_i)
        r_ovf <= 1'b1;
    end
  end

  assign fifo_wr_en_o   = r_push_pend & ~fifo_full_i;
  assign fifo_wr_data_o = r_push_data;
  assign busy_o         = r_busy;
  assign done_o         = r_done;
  assign overflow_o     = r_ovf;

endmodule
